// File: rtl/blake2s_digest_rx.sv
// -----------------------------------------------------------------------------
// blake2s_digest_rx
//
// Captures the digest that the BLAKE2s core streams out after it finishes.
// The core sends one byte per cycle. This block packs the bytes little-endian
// into a 256-bit word, then holds that word for a valid/ready handshake.
// It can also compare the digest against an expected value for
// known-answer self-test. Only the first nn_q bytes take part in the compare.
//
// Ports
//   clk            system clock, rising edge
//   nreset         asynchronous active-low reset
//   nn_i           requested digest length in bytes (0 or >NN_MAX means NN_MAX)
//   finished_i     core completion flag; its rising edge starts a capture
//   h_i            digest byte stream from the core
//   digest_ready_i downstream accepts the held digest
//   expect_en_i    enable the known-answer compare
//   expect_i       expected digest, little-endian bytes
//   digest_o       captured digest, byte k in bits [8k+7:8k], unused bytes 0
//   digest_len_o   number of valid bytes in digest_o
//   digest_v_o     digest valid (held until accepted)
//   match_o        masked compare result, only meaningful while valid
//   busy_o         capture in progress
//   overrun_o      sticky flag: a completion arrived that could not be taken
// -----------------------------------------------------------------------------
module blake2s_digest_rx #(
   parameter int NN_MAX = 32,
   parameter int CW     = 6
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic [7:0]            nn_i,
   input  logic                  finished_i,
   input  logic [7:0]            h_i,
   input  logic                  digest_ready_i,
   input  logic                  expect_en_i,
   input  logic [8*NN_MAX-1:0]   expect_i,
   output logic [8*NN_MAX-1:0]   digest_o,
   output logic [CW-1:0]         digest_len_o,
   output logic                  digest_v_o,
   output logic                  match_o,
   output logic                  busy_o,
   output logic                  overrun_o
);

   typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

   localparam logic [7:0]    NN_MAX_B = 8'(NN_MAX);
   localparam logic [CW-1:0] NN_MAX_C = CW'(NN_MAX);

   state_t              state_q;
   state_t              state_d;
   state_t              first_state;
   logic                finished_q;
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       nn_q;
   logic [CW-1:0]       nn_eff;
   logic [8*NN_MAX-1:0] digest_q;
   logic                overrun_q;
   logic                start;
   logic                transfer;
   logic                load;
   logic                lost;
   logic                mismatch;

   // Only the rising edge of finished_i starts a capture. A completion flag
   // that stays high must not retrigger.
   assign start    = finished_i & ~finished_q;
   assign transfer = (state_q == HOLD) & digest_ready_i;

   // A start is taken from IDLE. It is also taken from HOLD when the held
   // digest leaves in that same cycle, so the slot frees up just in time.
   // Any other start has nowhere to go and counts as an overrun.
   assign load = start & ((state_q == IDLE) | transfer);
   assign lost = start & ((state_q == CAPT) | ((state_q == HOLD) & ~digest_ready_i));

   // Length 0 means "default", and lengths above the maximum are clamped.
   assign nn_eff      = ((nn_i == 8'd0) || (nn_i > NN_MAX_B)) ? NN_MAX_C : nn_i[CW-1:0];
   assign first_state = (nn_eff == CW'(1)) ? HOLD : CAPT;

   // State register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Bytes arrive back to back, so CAPT leaves in the
   // same cycle it writes the last byte.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (load) begin
               state_d = first_state;
            end
         end
         CAPT: begin
            if ((count_q + CW'(1)) == nn_q) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (transfer) begin
               state_d = load ? first_state : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode. The compare ignores bytes beyond the captured length.
   always_comb begin
      busy_o     = (state_q == CAPT);
      digest_v_o = (state_q == HOLD);
      mismatch   = 1'b0;
      for (int i = 0; i < NN_MAX; i++) begin
         if ((CW'(i) < nn_q) && (digest_q[8*i +: 8] != expect_i[8*i +: 8])) begin
            mismatch = 1'b1;
         end
      end
      match_o = (state_q == HOLD) & expect_en_i & ~mismatch;
   end

   // Datapath. A new capture clears the whole word so that bytes past the
   // new length read as zero. After a transfer the word stays as it is
   // until the next start.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         finished_q <= 1'b0;
         count_q    <= '0;
         nn_q       <= '0;
         digest_q   <= '0;
         overrun_q  <= 1'b0;
      end else begin
         finished_q <= finished_i;
         if (load) begin
            digest_q <= {{(8*NN_MAX-8){1'b0}}, h_i};
            count_q  <= CW'(1);
            nn_q     <= nn_eff;
         end else if (state_q == CAPT) begin
            digest_q[8*int'(count_q) +: 8] <= h_i;
            count_q                        <= count_q + CW'(1);
         end
         if (lost) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign digest_o     = digest_q;
   assign digest_len_o = nn_q;
   assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_blake2s_digest_rx.sv
// -----------------------------------------------------------------------------
// tb_blake2s_digest_rx
//
// Directed sequence with randomized digest bytes and lengths. Expected
// digests are built from the byte list and the length rule. Each observation
// is compared with an immediate assertion.
// -----------------------------------------------------------------------------
module tb_blake2s_digest_rx;

   logic         clk;
   logic         nreset;
   logic [7:0]   nn_i;
   logic         finished_i;
   logic [7:0]   h_i;
   logic         digest_ready_i;
   logic         expect_en_i;
   logic [255:0] expect_i;
   logic [255:0] digest_o;
   logic [5:0]   digest_len_o;
   logic         digest_v_o;
   logic         match_o;
   logic         busy_o;
   logic         overrun_o;

   int checks = 0;
   int errors = 0;

   logic [7:0]   txBytes [32];
   logic [255:0] expDigest;
   int           expLen;

   blake2s_digest_rx dut (
      .clk            (clk),
      .nreset         (nreset),
      .nn_i           (nn_i),
      .finished_i     (finished_i),
      .h_i            (h_i),
      .digest_ready_i (digest_ready_i),
      .expect_en_i    (expect_en_i),
      .expect_i       (expect_i),
      .digest_o       (digest_o),
      .digest_len_o   (digest_len_o),
      .digest_v_o     (digest_v_o),
      .match_o        (match_o),
      .busy_o         (busy_o),
      .overrun_o      (overrun_o)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nnEff(input int req);
      return ((req == 0) || (req > 32)) ? 32 : req;
   endfunction

   function automatic logic [255:0] buildDigest(input int n);
      logic [255:0] d;
      d = '0;
      for (int k = 0; k < n; k++) d[8*k +: 8] = txBytes[k];
      return d;
   endfunction

   task automatic fillRandom();
      for (int k = 0; k < 32; k++) txBytes[k] = 8'($urandom);
   endtask

   task automatic resetDut();
      nreset         = 1'b0;
      finished_i     = 1'b0;
      digest_ready_i = 1'b0;
      #1;
      checkOutput("rst_overrun", overrun_o, 0);
      checkOutput("rst_valid", digest_v_o, 0);
      @(negedge clk);
      nreset = 1'b1;
   endtask

   // Starts a capture and streams nnEff(nnReq) bytes, checking the timing
   // on every cycle. glitchAt >= 2 makes finished_i rise again mid-stream.
   // readyAtStart accepts a held digest in the same cycle as the start.
   // holdFinished keeps finished_i high the whole time.
   task automatic applyStimulus(input logic [7:0] nnReq, input int glitchAt,
                                input bit readyAtStart, input bit holdFinished);
      int n;
      n         = nnEff(int'(nnReq));
      expLen    = n;
      expDigest = buildDigest(n);
      for (int k = 0; k < n; k++) begin
         nn_i           = (k == 0) ? nnReq : 8'($urandom);
         h_i            = txBytes[k];
         finished_i     = holdFinished ? 1'b1 : ((k == 0) || (k == glitchAt));
         digest_ready_i = (k == 0) ? readyAtStart : 1'b0;
         tick();
         if (k < n - 1) begin
            checkOutput("capt_valid_low", digest_v_o, 0);
            checkOutput("capt_busy", busy_o, 1);
         end
      end
      finished_i = holdFinished;
      h_i        = 8'($urandom);
      checkOutput("done_valid", digest_v_o, 1);
      checkOutput("done_busy", busy_o, 0);
      checkOutput("done_digest", digest_o, expDigest);
      checkOutput("done_len", digest_len_o, expLen);
      if (glitchAt >= 0) checkOutput("capt_overrun", overrun_o, 1);
   endtask

   task automatic doTransfer();
      digest_ready_i = 1'b1;
      tick();
      digest_ready_i = 1'b0;
      checkOutput("xfer_valid_low", digest_v_o, 0);
      checkOutput("xfer_busy", busy_o, 0);
      checkOutput("xfer_digest_kept", digest_o, expDigest);
   endtask

   // Directed sequence
   initial begin
      int n;
      int j;
      nreset         = 1'b0;
      nn_i           = 8'd0;
      finished_i     = 1'b0;
      h_i            = 8'd0;
      digest_ready_i = 1'b0;
      expect_en_i    = 1'b0;
      expect_i       = '0;
      #1;
      checkOutput("rst_digest", digest_o, 0);
      checkOutput("rst_len", digest_len_o, 0);
      checkOutput("rst_valid", digest_v_o, 0);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_overrun", overrun_o, 0);
      checkOutput("rst_match", match_o, 0);
      #20;
      @(negedge clk);
      nreset = 1'b1;

      // Reset in the middle of a 32-byte capture
      fillRandom();
      nn_i = 8'd32;
      for (int k = 0; k < 10; k++) begin
         h_i        = txBytes[k];
         finished_i = (k == 0);
         tick();
      end
      checkOutput("mid_busy", busy_o, 1);
      nreset = 1'b0;
      #1;
      checkOutput("abort_digest", digest_o, 0);
      checkOutput("abort_len", digest_len_o, 0);
      checkOutput("abort_valid", digest_v_o, 0);
      checkOutput("abort_busy", busy_o, 0);
      checkOutput("abort_overrun", overrun_o, 0);
      @(negedge clk);
      nreset = 1'b1;

      // Full 32-byte capture of an incrementing pattern
      for (int k = 0; k < 32; k++) txBytes[k] = 8'(k);
      applyStimulus(8'd32, -1, 1'b0, 1'b0);
      checkOutput("incr_const", digest_o,
                  256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100);
      doTransfer();

      // Short digest and masked compare
      txBytes[0] = 8'hAA; txBytes[1] = 8'hBB; txBytes[2] = 8'hCC; txBytes[3] = 8'hDD;
      applyStimulus(8'd4, -1, 1'b0, 1'b0);
      checkOutput("short_const", digest_o, 256'hDDCCBBAA);
      expect_en_i = 1'b1;
      expect_i    = {{224{1'b1}}, 32'hDDCCBBAA};
      #1;
      checkOutput("short_match", match_o, 1);
      expect_i[0] = ~expect_i[0];
      #1;
      checkOutput("short_mismatch", match_o, 0);
      expect_i[0] = ~expect_i[0];
      expect_en_i = 1'b0;
      #1;
      checkOutput("short_en_off", match_o, 0);
      expect_en_i = 1'b1;
      doTransfer();
      checkOutput("idle_match", match_o, 0);
      expect_en_i = 1'b0;

      // Length clamping
      fillRandom();
      applyStimulus(8'd0, -1, 1'b0, 1'b0);
      doTransfer();
      fillRandom();
      applyStimulus(8'd200, -1, 1'b0, 1'b0);
      doTransfer();
      fillRandom();
      applyStimulus(8'd1, -1, 1'b0, 1'b0);
      doTransfer();

      // Random lengths: masked compare and backpressure
      repeat (3) begin
         n = $urandom_range(1, 32);
         fillRandom();
         applyStimulus(8'(n), -1, 1'b0, 1'b0);
         for (int w = 0; w < 8; w++) expect_i[32*w +: 32] = $urandom();
         for (int k = 0; k < n; k++) expect_i[8*k +: 8] = txBytes[k];
         expect_en_i = 1'b1;
         #1;
         checkOutput("rand_match", match_o, 1);
         j = $urandom_range(0, n - 1);
         expect_i[8*j + 3] = ~expect_i[8*j + 3];
         #1;
         checkOutput("rand_mismatch", match_o, 0);
         expect_en_i = 1'b0;
         for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("bp_valid", digest_v_o, 1);
            checkOutput("bp_digest", digest_o, expDigest);
         end
         doTransfer();
      end

      // Overrun while capturing
      resetDut();
      fillRandom();
      applyStimulus(8'd16, 5, 1'b0, 1'b0);
      doTransfer();

      // Overrun while holding
      resetDut();
      fillRandom();
      applyStimulus(8'd12, -1, 1'b0, 1'b0);
      finished_i = 1'b1;
      h_i        = 8'h5A;
      nn_i       = 8'd3;
      tick();
      finished_i = 1'b0;
      tick();
      checkOutput("hold_overrun", overrun_o, 1);
      checkOutput("hold_valid", digest_v_o, 1);
      checkOutput("hold_digest", digest_o, expDigest);
      checkOutput("hold_len", digest_len_o, 12);
      doTransfer();

      // Back-to-back: new start in the same cycle as the transfer
      resetDut();
      fillRandom();
      applyStimulus(8'd8, -1, 1'b0, 1'b0);
      fillRandom();
      applyStimulus(8'd20, -1, 1'b1, 1'b0);
      checkOutput("b2b_overrun", overrun_o, 0);
      doTransfer();

      // finished_i held high for 40 cycles gives a single capture
      resetDut();
      fillRandom();
      applyStimulus(8'd8, -1, 1'b0, 1'b1);
      for (int c = 0; c < 32; c++) tick();
      checkOutput("lvl_valid", digest_v_o, 1);
      checkOutput("lvl_overrun", overrun_o, 0);
      doTransfer();
      repeat (5) tick();
      checkOutput("lvl_idle_valid", digest_v_o, 0);
      checkOutput("lvl_idle_busy", busy_o, 0);
      checkOutput("lvl_idle_overrun", overrun_o, 0);
      checkOutput("lvl_idle_digest", digest_o, expDigest);
      finished_i = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
